// File: rtl/result_writeback_arbiter_pkg.sv
// Shared result bus definitions for the writeback arbiter and its per-source FIFOs.
package result_writeback_arbiter_pkg;

  typedef logic [7:0] w8;
  typedef logic [7:0] r8;

  localparam int COMMIT_W  = 8;
  localparam int KIND_W    = 4;
  localparam int CONTENT_W = 37;

  // Producing unit class carried in the kind field.
  typedef enum logic [KIND_W-1:0] {
    K_ALU  = 4'd0,
    K_BU   = 4'd1,
    K_MEM  = 4'd2,
    K_UART = 4'd3,
    K_FPU  = 4'd4
  } kind_e;

  typedef struct packed {
    logic                 en;
    w8                    commit_id;
    logic [KIND_W-1:0]    kind;
    logic [CONTENT_W-1:0] content;
  } result_t;

  localparam int RESULT_W = $bits(result_t);

  // (a + b) mod n for operands already in [0, n).
  function automatic int wrap_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/result_writeback_arbiter_fifo.sv
// Per-source result FIFO; register storage so the head is combinational.
module result_skid_fifo
  import result_writeback_arbiter_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int RESULT_W = result_writeback_arbiter_pkg::RESULT_W
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                clear,
  input  logic                push,
  input  logic [RESULT_W-1:0] push_data,
  input  logic                pop,
  output logic [RESULT_W-1:0] head,
  output logic                empty,
  output logic                full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0][RESULT_W-1:0] mem;
  logic [AW-1:0]                  wr_ptr, rd_ptr;
  logic [CW-1:0]                  count;
  logic                           do_push, do_pop;

  // Full refuses a push even when the same cycle pops; clear drops everything.
  assign do_push = push & ~full & ~clear;
  assign do_pop  = pop & ~empty & ~clear;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign head  = mem[rd_ptr];

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/result_writeback_arbiter.sv
// Round-robin scheduler sharing the commit/writeback port between execution units.
module result_writeback_arbiter
  import result_writeback_arbiter_pkg::*;
#(
  parameter int NUM_SRC  = 7,
  parameter int DEPTH    = 4,
  parameter int RESULT_W = result_writeback_arbiter_pkg::RESULT_W
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  flash,
  input  logic                  stall,
  input  logic    [NUM_SRC-1:0] in_valid,
  input  result_t [NUM_SRC-1:0] in_data,
  output logic    [NUM_SRC-1:0] in_ready,
  output result_t               complete,
  output logic                  idle
);

  localparam int PTR_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]               empty, full, push, pop;
  logic [NUM_SRC-1:0][RESULT_W-1:0] head;
  logic [NUM_SRC-1:0]               req_rot;
  logic [PTR_W-1:0]                 rr_ptr, off, win_idx;
  logic                             win_vld, take;
  result_t                          out_reg;
  logic                             out_valid;
  logic                             unused_en;

  assign in_ready = ~full;
  assign take     = win_vld & ~stall & ~flash;

  // One FIFO per requesting unit.
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign push[g] = in_valid[g] & ~full[g] & ~flash;

    result_skid_fifo #(
      .DEPTH    (DEPTH),
      .RESULT_W (RESULT_W)
    ) u_fifo (
      .clock     (clock),
      .reset_n   (reset_n),
      .clear     (flash),
      .push      (push[g]),
      .push_data (in_data[g]),
      .pop       (pop[g]),
      .head      (head[g]),
      .empty     (empty[g]),
      .full      (full[g])
    );
  end

  // Rotate requests so rr_ptr sits at bit 0, then take the lowest set bit.
  always_comb begin
    req_rot = NUM_SRC'({~empty, ~empty} >> rr_ptr);
    win_vld = |req_rot;
    off     = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (req_rot[k]) off = PTR_W'(k);
    end
    win_idx = PTR_W'(wrap_add(int'(rr_ptr), int'(off), NUM_SRC));
  end

  // One-hot pop to the winning FIFO when the consumer can take a result.
  always_comb begin
    pop = '0;
    if (take) pop[win_idx] = 1'b1;
  end

  // Output register and round-robin pointer; flash dominates stall.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_reg   <= '0;
      out_valid <= 1'b0;
      rr_ptr    <= '0;
    end else if (flash) begin
      out_valid <= 1'b0;
      rr_ptr    <= '0;
    end else if (!stall) begin
      if (win_vld) begin
        out_reg   <= result_t'(head[win_idx]);
        out_valid <= 1'b1;
        rr_ptr    <= PTR_W'(wrap_add(int'(win_idx), 1, NUM_SRC));
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  // Present the held packet; en only when it is actually consumed this cycle.
  always_comb begin
    complete = '{en:        out_valid & ~stall & ~flash,
                 commit_id: out_reg.commit_id,
                 kind:      out_reg.kind,
                 content:   out_reg.content};
  end

  // The stored en bit is meaningless; the output qualifies it freshly.
  assign unused_en = out_reg.en;

  assign idle = (&empty) & ~out_valid;

endmodule

// File: tb/tb_result_writeback_arbiter.sv
// Randomized + directed bench with a queue-based reference model and output scoreboard.
module tb_result_writeback_arbiter;
  import result_writeback_arbiter_pkg::*;

  localparam int NS    = 7;
  localparam int DEPTH = 4;

  logic              clock   = 1'b0;
  logic              reset_n = 1'b0;
  logic              flash   = 1'b0;
  logic              stall   = 1'b0;
  logic [NS-1:0]     in_valid = '0;
  logic [NS-1:0]     in_ready;
  result_t [NS-1:0]  in_data = '0;
  result_t           complete;
  logic              idle;

  int checks = 0;
  int errors = 0;

  // Reference model: per-source queues, one output slot, round-robin start index.
  result_t mq [NS][$];
  result_t m_out;
  bit      m_out_valid = 0;
  int      m_rr = 0;
  result_t exp_q [$];
  logic [7:0] seq = 8'h80;

  always #5 clock = ~clock;

  result_writeback_arbiter #(.NUM_SRC(NS), .DEPTH(DEPTH), .RESULT_W(RESULT_W)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .flash    (flash),
    .stall    (stall),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .complete (complete),
    .idle     (idle)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic result_t mk(input logic [7:0] id);
    result_t r;
    r.en        = 1'($urandom);
    r.commit_id = id;
    r.kind      = KIND_W'($urandom);
    r.content   = CONTENT_W'({$urandom, $urandom});
    return r;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < NS; i++) mq[i].delete();
    m_out_valid = 0;
    m_rr        = 0;
  endfunction

  // Advance the model by one clock edge using the inputs held during that cycle.
  function automatic void model_edge();
    bit acc [NS];
    int w;
    if (flash) begin
      model_clear();
      return;
    end
    for (int i = 0; i < NS; i++) acc[i] = in_valid[i] && (mq[i].size() < DEPTH);
    if (!stall) begin
      w = -1;
      for (int k = 0; k < NS; k++) begin
        int j;
        j = (m_rr + k) % NS;
        if (w < 0 && mq[j].size() > 0) w = j;
      end
      if (w >= 0) begin
        m_out       = mq[w].pop_front();
        m_out_valid = 1;
        m_rr        = (w + 1) % NS;
      end else begin
        m_out_valid = 0;
      end
    end
    for (int i = 0; i < NS; i++) if (acc[i]) mq[i].push_back(in_data[i]);
  endfunction

  // Apply inputs for this cycle and check registered-state outputs against the model.
  task automatic drive(input bit s, input bit f, input logic [NS-1:0] v);
    logic [NS-1:0] rdy;
    bit            all_empty;
    bit            pres;
    stall    = s;
    flash    = f;
    in_valid = v;
    #1;
    all_empty = 1;
    for (int i = 0; i < NS; i++) begin
      rdy[i] = (mq[i].size() != DEPTH);
      if (mq[i].size() != 0) all_empty = 0;
    end
    pres = m_out_valid && !s && !f;
    chk("in_ready", 64'(in_ready), 64'(rdy));
    chk("idle", 64'(idle), 64'(all_empty && !m_out_valid));
    chk("complete_en", 64'(complete.en), 64'(pres));
    if (pres) exp_q.push_back(m_out);
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, '0);
      tick();
    end
  endtask

  // Asynchronous reset pulse starting mid-cycle; idle must rise with no clock edge.
  task automatic async_reset();
    stall    = 0;
    flash    = 0;
    in_valid = '0;
    reset_n  = 0;
    #1;
    chk("areset_idle", 64'(idle), 64'(1));
    chk("areset_en", 64'(complete.en), 64'(0));
    chk("areset_ready", 64'(in_ready), 64'({NS{1'b1}}));
    model_clear();
    #2;
    reset_n = 1;
    tick();
  endtask

  // Scoreboard monitor: every presented packet must match the next model prediction.
  initial begin
    result_t e;
    forever begin
      @(negedge clock);
      if (reset_n && complete.en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=%0h required=none", complete.commit_id);
        end else begin
          e = exp_q.pop_front();
          chk("complete_data", 64'({complete.commit_id, complete.kind, complete.content}),
              64'({e.commit_id, e.kind, e.content}));
        end
      end
    end
  end

  initial begin
    logic [NS-1:0] v;
    logic [7:0]    got [$];
    int            pos;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("reset_idle", 64'(idle), 64'(1));
    chk("reset_ready", 64'(in_ready), 64'({NS{1'b1}}));
    chk("reset_en", 64'(complete.en), 64'(0));
    reset_n = 1;

    // Single push on src2: visible the cycle after the second edge
    in_data[2] = mk(8'h11);
    drive(0, 0, NS'(1) << 2); tick();
    drive(0, 0, '0);
    chk("t1_not_idle", 64'(idle), 64'(0));
    tick();
    drive(0, 0, '0);
    chk("t1_en", 64'(complete.en), 64'(1));
    chk("t1_id", 64'(complete.commit_id), 64'(8'h11));
    tick();
    drive(0, 0, '0);
    chk("t1_idle_back", 64'(idle), 64'(1));
    tick();

    // All sources at once from rr_ptr=0: ids 0..6 in index order
    drive(0, 1, '0); tick();
    for (int i = 0; i < NS; i++) in_data[i] = mk(8'(i));
    drive(0, 0, '1); tick();
    drive(0, 0, '0); tick();
    for (int k = 0; k < NS; k++) begin
      drive(0, 0, '0);
      chk("t2_en", 64'(complete.en), 64'(1));
      chk("t2_order", 64'(complete.commit_id), 64'(k));
      tick();
    end
    in_data[0] = mk(8'h70);
    in_data[6] = mk(8'h76);
    drive(0, 0, NS'(7'b1000001)); tick();
    drive(0, 0, '0); tick();
    drive(0, 0, '0);
    chk("t2_rr_wrapped", 64'(complete.commit_id), 64'(8'h70));
    tick();
    idle_cycles(3);

    // Src0 streaming while src5 waits with one packet
    got.delete();
    for (int n = 0; n < 8; n++) begin
      in_data[0] = mk(8'(8'h30 + n));
      in_data[5] = mk(8'h55);
      drive(0, 0, (n == 0) ? NS'(7'b0100001) : NS'(1));
      if (complete.en) got.push_back(complete.commit_id);
      tick();
    end
    pos = -1;
    for (int i = got.size() - 1; i >= 0; i--) if (got[i] == 8'h55) pos = i;
    chk("t3_src5_within_2", 64'(pos >= 0 && pos < 2), 64'(1));
    idle_cycles(12);

    // Fill src1 under stall; fifth push refused
    drive(0, 1, '0); tick();
    for (int n = 0; n < DEPTH; n++) begin
      in_data[1] = mk(8'(8'h40 + n));
      drive(1, 0, NS'(2)); tick();
    end
    in_data[1] = mk(8'h44);
    drive(1, 0, NS'(2));
    chk("t4_full", 64'(in_ready[1]), 64'(0));
    tick();
    drive(0, 0, '0); tick();
    drive(0, 0, '0);
    chk("t4_ready_after_pop", 64'(in_ready[1]), 64'(1));
    chk("t4_first", 64'(complete.commit_id), 64'(8'h40));
    tick();
    idle_cycles(6);

    // Held output across a 3-cycle stall, presented once
    drive(0, 1, '0); tick();
    in_data[3] = mk(8'h20);
    drive(0, 0, NS'(8)); tick();
    drive(0, 0, '0); tick();
    for (int n = 0; n < 3; n++) begin
      drive(1, 0, '0);
      chk("t5_stall_en", 64'(complete.en), 64'(0));
      tick();
    end
    drive(0, 0, '0);
    chk("t5_release_id", 64'(complete.commit_id), 64'(8'h20));
    chk("t5_release_en", 64'(complete.en), 64'(1));
    tick();
    idle_cycles(2);

    // Flash with queued + held results and a simultaneous push
    for (int n = 0; n < DEPTH; n++) begin
      in_data[0] = mk(8'(8'h60 + n));
      drive(1, 0, NS'(1)); tick();
    end
    drive(0, 0, '0); tick();
    for (int i = 0; i < NS; i++) in_data[i] = mk(8'hE0);
    drive(0, 1, '1);
    chk("t6_flash_en", 64'(complete.en), 64'(0));
    tick();
    drive(0, 0, '0);
    chk("t6_idle_after_flash", 64'(idle), 64'(1));
    tick();

    // Async reset mid-stream
    in_data[2] = mk(8'hA2);
    in_data[3] = mk(8'hA3);
    drive(0, 0, NS'(12)); tick();
    drive(0, 0, NS'(12)); tick();
    async_reset();
    idle_cycles(2);

    // Randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NS; i++) begin
        in_data[i] = mk(seq);
        seq = seq + 8'd1;
        v[i] = ($urandom_range(0, 99) < 45);
      end
      if ($urandom_range(0, 399) == 0) begin
        async_reset();
      end else begin
        drive($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 3, v);
        tick();
      end
    end
    idle_cycles(NS * DEPTH + 4);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
